// File: rtl/operand_loader.sv
// Operand entry sequencer for the complex multiplier: four handshake-stepped captures,
// a fixed-latency wait, then latched results shown on the LEDs. Optional macro: LOADER_SYNC_EN.
module operand_loader #(
   parameter int WORD_WIDTH   = 8,
   parameter int MULT_LATENCY = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WORD_WIDTH-1:0] sw_data,
   input  logic                  handshake,
   input  logic [WORD_WIDTH-1:0] re_res,
   input  logic [WORD_WIDTH-1:0] im_res,
   output logic [WORD_WIDTH-1:0] re_a,
   output logic [WORD_WIDTH-1:0] im_a,
   output logic [WORD_WIDTH-1:0] re_q,
   output logic [WORD_WIDTH-1:0] im_q,
   output logic [WORD_WIDTH-1:0] led,
   output logic [2:0]            stage,
   output logic                  res_valid
);

   typedef enum logic [2:0] {
      LOAD_RE_A = 3'd0,
      LOAD_IM_A = 3'd1,
      LOAD_RE_Q = 3'd2,
      LOAD_IM_Q = 3'd3,
      WAIT      = 3'd4,
      SHOW_RE   = 3'd5,
      SHOW_IM   = 3'd6
   } state_t;

   localparam int CNT_W = (MULT_LATENCY < 1) ? 1 : $clog2(MULT_LATENCY + 1);
   localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MULT_LATENCY);

   state_t                state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [WORD_WIDTH-1:0] re_a_q, im_a_q, re_q_q, im_q_q;
   logic [WORD_WIDTH-1:0] re_lat_q, im_lat_q, led_q;
   logic                  hs_prev_q;
   logic                  hs;
   logic                  hs_edge;

`ifdef LOADER_SYNC_EN
   // Reset high so a switch already up at reset release produces no edge.
   logic [1:0] sync_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], handshake};
   end
   assign hs = sync_q[1];
`else
   assign hs = handshake;
`endif

   assign hs_edge = hs & ~hs_prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= LOAD_RE_A;
         cnt_q     <= '0;
         re_a_q    <= '0;
         im_a_q    <= '0;
         re_q_q    <= '0;
         im_q_q    <= '0;
         re_lat_q  <= '0;
         im_lat_q  <= '0;
         led_q     <= '0;
         hs_prev_q <= 1'b1;
      end else begin
         hs_prev_q <= hs;
         case (state_q)
            LOAD_RE_A: begin
               led_q <= sw_data;
               if (hs_edge) begin
                  re_a_q  <= sw_data;
                  state_q <= LOAD_IM_A;
               end
            end
            LOAD_IM_A: begin
               led_q <= sw_data;
               if (hs_edge) begin
                  im_a_q  <= sw_data;
                  state_q <= LOAD_RE_Q;
               end
            end
            LOAD_RE_Q: begin
               led_q <= sw_data;
               if (hs_edge) begin
                  re_q_q  <= sw_data;
                  state_q <= LOAD_IM_Q;
               end
            end
            LOAD_IM_Q: begin
               led_q <= sw_data;
               if (hs_edge) begin
                  im_q_q  <= sw_data;
                  cnt_q   <= '0;
                  state_q <= WAIT;
               end
            end
            // Edges here are consumed by hs_prev_q and never queued.
            WAIT: begin
               if (cnt_q == LAT_CNT) begin
                  re_lat_q <= re_res;
                  im_lat_q <= im_res;
                  cnt_q    <= '0;
                  state_q  <= SHOW_RE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            SHOW_RE: begin
               led_q <= re_lat_q;
               if (hs_edge) state_q <= SHOW_IM;
            end
            SHOW_IM: begin
               led_q <= im_lat_q;
               if (hs_edge) state_q <= LOAD_RE_A;
            end
            default: state_q <= LOAD_RE_A;
         endcase
      end
   end

   always_comb begin
      led = led_q;
      case (state_q)
         LOAD_RE_A, LOAD_IM_A, LOAD_RE_Q, LOAD_IM_Q: led = sw_data;
         SHOW_RE: led = re_lat_q;
         SHOW_IM: led = im_lat_q;
         default: led = led_q;
      endcase
   end

   assign re_a      = re_a_q;
   assign im_a      = im_a_q;
   assign re_q      = re_q_q;
   assign im_q      = im_q_q;
   assign stage     = state_q;
   assign res_valid = (state_q == SHOW_RE) || (state_q == SHOW_IM);

endmodule
